shkrimi_prapa_24b: RTL
======================

# shkrimi_prapa_24b

Writeback unit of the 24-bit CPU. It accepts one execution result per handshake and writes it into the 24-bit register file. The result is selected by the 3-bit operation code: an ALU result, a 48-bit multiplier result, or memory load data. A 48-bit product is written as two 24-bit words on consecutive cycles, low word first. The block sits between the execute-stage result selection and the register-file write port.

## Interface
Parameters:
- ADRESA_W, 4, register-file address width; register file holds 2^ADRESA_W words.

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Valid  input  1  producer has a result this cycle.
- Gati  output  1  block can accept a result this cycle; transfer occurs when Valid && Gati.
- S  input  3  operation code: 000/001/010/011/101 = ALU, 100 = MUL, 110 = memory load, 111 = no write.
- Hyrja_ALU  input  24  ALU result.
- Hyrja_MUL  input  48  multiplier product.
- Hyrja_MEM  input  24  load data.
- Rd  input  ADRESA_W  destination register; for MUL, low word goes to Rd and high word to Rd+1.
- RegWrite  output  1  register-file write enable.
- AdresaShkrimit  output  ADRESA_W  register-file write address.
- TeDhenat  output  24  register-file write data.
- Busy  output  1  high while a captured MUL high word is still pending.

## Operation
- FSM states:
  - IDLE: no write this cycle.
  - SHKRIM: one write in flight; for MUL this is the low word.
  - SHKRIM_HI: MUL high word.
- Gati is combinational:
  - 1 in IDLE, in SHKRIM when the captured op is not MUL, and in SHKRIM_HI.
  - 0 in SHKRIM when the captured op is MUL.
  - 0 while Reset is high.
- On a transfer with S in {000,001,010,011,101}:
  - Capture Hyrja_ALU and Rd; next state SHKRIM.
- On a transfer with S=110:
  - Capture Hyrja_MEM and Rd; next state SHKRIM.
- On a transfer with S=100:
  - Capture the full 48-bit Hyrja_MUL and Rd; next state SHKRIM.
  - From SHKRIM go to SHKRIM_HI unconditionally.
- On a transfer with S=111:
  - Accepted, no write; next state IDLE.
- With no transfer, SHKRIM (non-MUL) and SHKRIM_HI return to IDLE.
- When a transfer occurs in SHKRIM or SHKRIM_HI, the next state comes from the new S. This gives back-to-back writes with no bubble.
- Address arithmetic: high-word address is Rd+1 modulo 2^ADRESA_W, so the highest register wraps to register 0.
- Inputs are sampled only on the transfer edge; changes on S, Rd or data while Gati=0 are ignored.

## Timing
- All outputs except Gati are registered.
- Reset values: RegWrite=0, AdresaShkrimit=0, TeDhenat=0, Busy=0, state IDLE.
- Reset mid-MUL: the pending high word is dropped; no write in the cycle after Reset deasserts.
- Latency for a transfer at edge N:
  - Non-MUL: RegWrite=1 with the captured data during cycle N..N+1 (visible after edge N), exactly one cycle.
  - MUL: low word after edge N, high word after edge N+1, with RegWrite high both cycles.
- Busy=1 exactly during the low-word cycle of a MUL.
- Throughput: 1 result/cycle for ALU/MEM/no-write ops; a MUL occupies 2 cycles.
- A MUL following a MUL: the second is accepted in the SHKRIM_HI cycle, so four write cycles run contiguously.
- When the cycle after a write has no transfer, RegWrite=0. AdresaShkrimit and TeDhenat hold their last values.

## Test plan
- Reset, then idle: RegWrite=0, Gati=1, Busy=0, and all outputs 0 for 5 cycles.
- Back-to-back ALU ops:
  - Stimulus: S=000 with Hyrja_ALU=0x123456, Rd=3, then S=101 with 0xABCDEF, Rd=4 on consecutive cycles.
  - Response: writes (3,0x123456) then (4,0xABCDEF) on consecutive cycles; Gati held 1.
- MUL with wrap:
  - Stimulus: S=100, Hyrja_MUL=0xFEDCBA987654, Rd=15.
  - Response: write (15,0x987654) with Busy=1 and Gati=0, then (0,0xFEDCBA); next cycle RegWrite=0.
- Load and no-write mix:
  - Stimulus: S=110 with Hyrja_MEM=0x00FF00, Rd=7, then S=111, Rd=8.
  - Response: single write (7,0x00FF00), then RegWrite=0.
- MUL followed immediately by ALU:
  - Stimulus: S=100 held valid into an S=011 transfer.
  - Response: ALU op not accepted during the low-word cycle; accepted during SHKRIM_HI; writes are low, high, ALU on three consecutive cycles.
- Reset asserted on the low-word cycle of a MUL: no high-word write appears, and outputs return to reset values.

Source files
------------

// File: rtl/shkrimi_prapa_24b.sv
// Writeback unit: turns one accepted execute result into register-file writes;
// a 48-bit product is split into a low-word write followed by a high-word write.
module shkrimi_prapa_24b #(
    parameter int ADRESA_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                gati_o,
    input  logic [2:0]          s_i,
    input  logic [23:0]         hyrja_alu_i,
    input  logic [47:0]         hyrja_mul_i,
    input  logic [23:0]         hyrja_mem_i,
    input  logic [ADRESA_W-1:0] rd_i,
    output logic                reg_write_o,
    output logic [ADRESA_W-1:0] adresa_shkrimit_o,
    output logic [23:0]         te_dhenat_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHKRIM    = 2'd1,
        SHKRIM_HI = 2'd2
    } gjendje_t;

    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_MEM  = 3'b110;
    localparam logic [2:0] OP_NONE = 3'b111;
    localparam logic [ADRESA_W-1:0] NJE = {{(ADRESA_W-1){1'b0}}, 1'b1};

    gjendje_t              state_q, state_d;
    logic                  is_mul_q, is_mul_d;
    logic [23:0]           hi_q, hi_d;
    logic [ADRESA_W-1:0]   adr_hi_q, adr_hi_d;
    logic                  reg_write_q, reg_write_d;
    logic [ADRESA_W-1:0]   adr_q, adr_d;
    logic [23:0]           data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  transfer;

    // Stall only while the low word of a product is out; the high word is then
    // already captured, so a new result can be taken during SHKRIM_HI.
    assign gati_o   = !rst_i && !(state_q == SHKRIM && is_mul_q);
    assign transfer = valid_i && gati_o;

    always_comb begin
        state_d     = IDLE;
        is_mul_d    = 1'b0;
        hi_d        = hi_q;
        adr_hi_d    = adr_hi_q;
        reg_write_d = 1'b0;
        adr_d       = adr_q;
        data_d      = data_q;
        busy_d      = 1'b0;

        if (transfer) begin
            case (s_i)
                OP_NONE: begin
                    state_d = IDLE;
                end
                OP_MUL: begin
                    state_d     = SHKRIM;
                    is_mul_d    = 1'b1;
                    hi_d        = hyrja_mul_i[47:24];
                    adr_hi_d    = rd_i + NJE;
                    reg_write_d = 1'b1;
                    adr_d       = rd_i;
                    data_d      = hyrja_mul_i[23:0];
                    busy_d      = 1'b1;
                end
                OP_MEM: begin
                    state_d     = SHKRIM;
                    reg_write_d = 1'b1;
                    adr_d       = rd_i;
                    data_d      = hyrja_mem_i;
                end
                default: begin
                    state_d     = SHKRIM;
                    reg_write_d = 1'b1;
                    adr_d       = rd_i;
                    data_d      = hyrja_alu_i;
                end
            endcase
        end else if (state_q == SHKRIM && is_mul_q) begin
            state_d     = SHKRIM_HI;
            reg_write_d = 1'b1;
            adr_d       = adr_hi_q;
            data_d      = hi_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            is_mul_q    <= 1'b0;
            hi_q        <= '0;
            adr_hi_q    <= '0;
            reg_write_q <= 1'b0;
            adr_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_mul_q    <= is_mul_d;
            hi_q        <= hi_d;
            adr_hi_q    <= adr_hi_d;
            reg_write_q <= reg_write_d;
            adr_q       <= adr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
        end
    end

    assign reg_write_o       = reg_write_q;
    assign adresa_shkrimit_o = adr_q;
    assign te_dhenat_o       = data_q;
    assign busy_o            = busy_q;

endmodule
